// File: rtl/id_stage_if.sv
// Fetch-side, regfile, bypass and execute-side signals of the RV32I decode stage.
// The slave modport is the decode stage's view; master is the surrounding pipeline.
interface id_stage_if #(
    parameter int XLEN = 32
);
    logic            flush;
    logic            if_valid;
    logic            if_ready;
    logic [31:0]     if_inst;
    logic [XLEN-1:0] if_pc;
    logic [4:0]      rs1_address;
    logic [4:0]      rs2_address;
    logic [XLEN-1:0] rs1_value;
    logic [XLEN-1:0] rs2_value;
    logic            mem_valid;
    logic [4:0]      mem_rd;
    logic [XLEN-1:0] mem_value;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_value;
    logic            ex_valid;
    logic            ex_ready;
    logic [XLEN-1:0] ex_pc;
    logic [XLEN-1:0] ex_rs1_data;
    logic [XLEN-1:0] ex_rs2_data;
    logic [XLEN-1:0] ex_imm;
    logic [4:0]      ex_rd;
    logic [6:0]      ex_opcode;
    logic [2:0]      ex_funct3;
    logic            ex_funct7b5;
    logic            ex_is_load;
    logic            ex_illegal;

    modport slave (
        input  flush, if_valid, if_inst, if_pc, rs1_value, rs2_value,
               mem_valid, mem_rd, mem_value, wb_rd, wb_value, ex_ready,
        output if_ready, rs1_address, rs2_address, ex_valid, ex_pc,
               ex_rs1_data, ex_rs2_data, ex_imm, ex_rd, ex_opcode,
               ex_funct3, ex_funct7b5, ex_is_load, ex_illegal
    );

    modport master (
        output flush, if_valid, if_inst, if_pc, rs1_value, rs2_value,
               mem_valid, mem_rd, mem_value, wb_rd, wb_value, ex_ready,
        input  if_ready, rs1_address, rs2_address, ex_valid, ex_pc,
               ex_rs1_data, ex_rs2_data, ex_imm, ex_rd, ex_opcode,
               ex_funct3, ex_funct7b5, ex_is_load, ex_illegal
    );
endinterface

// File: rtl/id_stage.sv
// RV32I decode / register-read stage: immediate generation, MEM/WB bypass, load-use stall, ID/EX register.
// Optional performance counters (perf_bubbles, perf_flushes) are built when ID_STAGE_PERF_EN is defined.
module id_stage #(
    parameter int          XLEN     = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    id_stage_if.slave   bus
`ifdef ID_STAGE_PERF_EN
    ,
    output logic [31:0] perf_bubbles,
    output logic [31:0] perf_flushes
`endif
);
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_MISC   = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    // Priority: x0, then EX/MEM result, then the value being written back, then the regfile.
    function automatic logic [XLEN-1:0] bypass(
        input logic [4:0]      a,
        input logic            mv,
        input logic [4:0]      mrd,
        input logic [XLEN-1:0] mval,
        input logic [4:0]      wrd,
        input logic [XLEN-1:0] wval,
        input logic [XLEN-1:0] rfval
    );
        if (a == 5'd0)              return '0;
        else if (mv && (mrd == a))  return mval;
        else if (wrd == a)          return wval;
        else                        return rfval;
    endfunction

    // Opcodes outside the RV32I set (including any with inst[1:0] != 2'b11) fall to zero.
    function automatic logic signed [31:0] gen_imm(input logic [31:0] i);
        case (i[6:0])
            OPC_OPIMM, OPC_LOAD, OPC_JALR, OPC_MISC, OPC_SYSTEM:
                return {{20{i[31]}}, i[31:20]};
            OPC_STORE:
                return {{20{i[31]}}, i[31:25], i[11:7]};
            OPC_BRANCH:
                return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            OPC_LUI, OPC_AUIPC:
                return {i[31:12], 12'b0};
            OPC_JAL:
                return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            default:
                return '0;
        endcase
    endfunction

    logic [31:0]      w_inst;
    logic [6:0]       w_opcode;
    logic [4:0]       w_rs1;
    logic [4:0]       w_rs2;
    logic             w_uses_rs1;
    logic             w_uses_rs2;
    logic             w_legal;
    logic             w_has_rd;
    logic             w_hazard;
    logic             w_advance;
    logic             w_transfer;
    logic signed [31:0] w_imm;
    logic [XLEN-1:0]  w_rs1_byp;
    logic [XLEN-1:0]  w_rs2_byp;

    logic             r_vld_p1;
    logic [XLEN-1:0]  r_pc_p1;
    logic [XLEN-1:0]  r_rs1_p1;
    logic [XLEN-1:0]  r_rs2_p1;
    logic [XLEN-1:0]  r_imm_p1;
    logic [4:0]       r_rd_p1;
    logic [6:0]       r_opcode_p1;
    logic [2:0]       r_funct3_p1;
    logic             r_funct7b5_p1;
    logic             r_is_load_p1;
    logic             r_illegal_p1;

    assign w_inst   = bus.if_inst;
    assign w_opcode = w_inst[6:0];
    assign w_rs1    = w_inst[19:15];
    assign w_rs2    = w_inst[24:20];

    assign bus.rs1_address = w_rs1;
    assign bus.rs2_address = w_rs2;

    always_comb begin
        w_uses_rs1 = !(w_opcode inside {OPC_LUI, OPC_AUIPC, OPC_JAL});
        w_uses_rs2 = w_opcode inside {OPC_BRANCH, OPC_STORE, OPC_OP};
        w_legal    = w_opcode inside {OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
                                      OPC_LOAD, OPC_STORE, OPC_OPIMM, OPC_OP, OPC_MISC,
                                      OPC_SYSTEM};
        w_has_rd   = !(w_opcode inside {OPC_BRANCH, OPC_STORE});
    end

    assign w_imm     = gen_imm(w_inst);
    assign w_rs1_byp = bypass(w_rs1, bus.mem_valid, bus.mem_rd, bus.mem_value,
                              bus.wb_rd, bus.wb_value, bus.rs1_value);
    assign w_rs2_byp = bypass(w_rs2, bus.mem_valid, bus.mem_rd, bus.mem_value,
                              bus.wb_rd, bus.wb_value, bus.rs2_value);

    // A load still in ID/EX has no value to forward yet, so its consumer must wait one cycle.
    assign w_hazard   = r_vld_p1 && r_is_load_p1 && (r_rd_p1 != 5'd0) &&
                        ((w_uses_rs1 && (r_rd_p1 == w_rs1)) ||
                         (w_uses_rs2 && (r_rd_p1 == w_rs2)));
    assign w_advance  = !r_vld_p1 || bus.ex_ready;
    assign w_transfer = bus.if_valid && w_advance && !w_hazard && !bus.flush;

    assign bus.if_ready = !rst && (bus.flush || (w_advance && !w_hazard));

    // ---- ID/EX register (p1) ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld_p1      <= 1'b0;
            r_pc_p1       <= RESET_PC;
            r_rs1_p1      <= '0;
            r_rs2_p1      <= '0;
            r_imm_p1      <= '0;
            r_rd_p1       <= '0;
            r_opcode_p1   <= '0;
            r_funct3_p1   <= '0;
            r_funct7b5_p1 <= 1'b0;
            r_is_load_p1  <= 1'b0;
            r_illegal_p1  <= 1'b0;
        end else if (bus.flush) begin
            r_vld_p1 <= 1'b0;
        end else if (w_advance) begin
            if (w_transfer) begin
                r_vld_p1      <= 1'b1;
                r_pc_p1       <= bus.if_pc;
                r_rs1_p1      <= w_rs1_byp;
                r_rs2_p1      <= w_rs2_byp;
                r_imm_p1      <= w_imm;
                r_rd_p1       <= w_has_rd ? w_inst[11:7] : 5'd0;
                r_opcode_p1   <= w_opcode;
                r_funct3_p1   <= w_inst[14:12];
                r_funct7b5_p1 <= w_inst[30];
                r_is_load_p1  <= (w_opcode == OPC_LOAD);
                r_illegal_p1  <= !w_legal;
            end else begin
                r_vld_p1 <= 1'b0;
            end
        end
    end

    assign bus.ex_valid    = r_vld_p1;
    assign bus.ex_pc       = r_pc_p1;
    assign bus.ex_rs1_data = r_rs1_p1;
    assign bus.ex_rs2_data = r_rs2_p1;
    assign bus.ex_imm      = r_imm_p1;
    assign bus.ex_rd       = r_rd_p1;
    assign bus.ex_opcode   = r_opcode_p1;
    assign bus.ex_funct3   = r_funct3_p1;
    assign bus.ex_funct7b5 = r_funct7b5_p1;
    assign bus.ex_is_load  = r_is_load_p1;
    assign bus.ex_illegal  = r_illegal_p1;

`ifdef ID_STAGE_PERF_EN
    logic [31:0] r_bubbles;
    logic [31:0] r_flushes;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bubbles <= '0;
            r_flushes <= '0;
        end else begin
            if (!bus.flush && w_advance && w_hazard) r_bubbles <= r_bubbles + 32'd1;
            if (bus.flush && r_vld_p1)               r_flushes <= r_flushes + 32'd1;
        end
    end

    assign perf_bubbles = r_bubbles;
    assign perf_flushes = r_flushes;
`endif
endmodule
